pk_detect_ctrl: RTL and testbench
=================================

// Module: pk_detect_ctrl
// PURPOSE
//  Control side of the MB MCU peak-detector handshake. On a sample request it raises
//  pk_detect_reset (carried to the MCU by MB_SPI_IO), waits for pk_detect_ack, captures
//  the forward/reverse power words (AIN1/AIN2) delivered in that same frame, then
//  completes the 4-phase handshake. Sits between MB_SPI_IO and the C&C/telemetry logic.
// PARAMETERS
//  TIMEOUT_CYCLES  1000000  clocks allowed per wait state before abort (>=2)
//  TW              20       timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clock            in   1   system clock (same domain as MB_SPI_IO)
//  reset            in   1   synchronous, active-high reset
//  sample_req       in   1   1-clock pulse: request a new peak sample
//  peak_clear       in   1   1-clock pulse: clear fwd_peak/rev_peak
//  AIN1             in   12  forward power word from MB_SPI_IO
//  AIN2             in   12  reverse power word from MB_SPI_IO
//  pk_detect_ack    in   1   MCU ack, level, from MB_SPI_IO
//  pk_detect_reset  out  1   request to MCU: reset peak detector, level
//  fwd_power        out  12  last captured forward power
//  rev_power        out  12  last captured reverse power
//  fwd_peak         out  12  max fwd_power since reset/peak_clear
//  rev_peak         out  12  max rev_power since reset/peak_clear
//  pwr_valid        out  1   1-clock pulse, cycle after capture
//  busy             out  1   1 while state != IDLE
//  timeout_err      out  1   sticky; set on abort, cleared on next good capture
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; pending flag 0; timeout counter 0.
//  States (one-hot or binary, implementer's choice):
//   IDLE:    pk_detect_reset=0. If (sample_req|pending): ack=1 -> DRAIN, ack=0 -> ARM;
//            pending<=0.
//   DRAIN:   stale ack from earlier frame; pk_detect_reset=0; ack=0 -> ARM.
//   ARM:     pk_detect_reset=1; on ack=1 capture fwd_power<=AIN1, rev_power<=AIN2
//            in that cycle (AIN and ack update together) -> RELEASE.
//   RELEASE: pk_detect_reset=0; on ack=0 -> IDLE.
//  pk_detect_reset is registered: high from the cycle after ARM entry through the
//   capture cycle; low from the first RELEASE cycle.
//  Capture cycle +1: pwr_valid=1 for one clock; timeout_err<=0;
//   fwd_peak<=max(fwd_peak,captured fwd), rev_peak likewise (unsigned compare).
//  Timeout: counter clears on every state entry, increments each clock in DRAIN/ARM/
//   RELEASE; reaching TIMEOUT_CYCLES -> timeout_err<=1, pk_detect_reset<=0, -> IDLE;
//   no pwr_valid, fwd/rev values unchanged. Counter never wraps.
//  sample_req while busy: sets pending (single-depth, further reqs merged); served on
//   IDLE return. sample_req in same cycle as RELEASE->IDLE: pending set, served next.
//  peak_clear: peaks<=0 next clock; if same cycle as peak update, peaks<=captured
//   values (clear then update).
//  Stray ack rise in IDLE/RELEASE: ignored (no capture).
//  reset mid-handshake: immediate IDLE, pk_detect_reset=0 next clock, pending lost.
// TESTING
//  1 req; ack rises 5 clk after pk_detect_reset, AIN1=0x3A5 AIN2=0x012; ack falls 5 clk
//    after reset drops -> fwd_power=0x3A5, rev_power=0x012, one pwr_valid, busy low.
//  2 TIMEOUT_CYCLES=16, req, ack never rises -> reset high 16 clk then low,
//    timeout_err=1, no pwr_valid; next good handshake clears timeout_err.
//  3 ack=1 at req -> pk_detect_reset stays 0 until ack low (DRAIN), then normal capture.
//  4 three reqs during one handshake -> exactly two captures total, two pwr_valid.
//  5 captures 0x100,0x2FF,0x050 -> fwd_peak=0x2FF; peak_clear then 0x010 -> 0x010.
//  6 reset asserted while in ARM -> pk_detect_reset 0 next clock, all outputs 0.

Source files
------------

// File: rtl/pk_detect_ctrl.sv
// pk_detect_ctrl: 4-phase peak-detector handshake with power capture, peak tracking and timeout
module pk_detect_ctrl #(
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int TW             = 20
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        sample_req,
   input  logic        peak_clear,
   input  logic [11:0] AIN1,
   input  logic [11:0] AIN2,
   input  logic        pk_detect_ack,
   output logic        pk_detect_reset,
   output logic [11:0] fwd_power,
   output logic [11:0] rev_power,
   output logic [11:0] fwd_peak,
   output logic [11:0] rev_peak,
   output logic        pwr_valid,
   output logic        busy,
   output logic        timeout_err
);
   typedef enum logic [1:0] {IDLE, DRAIN, ARM, RELEASE} state_t;
   state_t state_q, state_d, nxt;
   logic [TW-1:0] cnt_q, cnt_d;
   logic pending_q, pending_d, capture, abort;
   logic pk_detect_reset_q, pk_detect_reset_d, busy_q, busy_d;
   logic pwr_valid_q, pwr_valid_d, timeout_err_q, timeout_err_d;
   logic [11:0] fwd_power_q, fwd_power_d, rev_power_q, rev_power_d;
   logic [11:0] fwd_peak_q, fwd_peak_d, rev_peak_q, rev_peak_d, fwd_max, rev_max;
   always_comb begin
      nxt = state_q == IDLE  ? ((sample_req | pending_q) ? (pk_detect_ack ? DRAIN : ARM) : IDLE) :
            state_q == DRAIN ? (pk_detect_ack ? DRAIN : ARM) :
            state_q == ARM   ? (pk_detect_ack ? RELEASE : ARM) :
                               (pk_detect_ack ? RELEASE : IDLE);
      // a completing handshake step wins over an expiring timer
      abort = state_q != IDLE && nxt == state_q && cnt_q == TW'(TIMEOUT_CYCLES - 1);
      capture = state_q == ARM && pk_detect_ack;
      state_d = abort ? IDLE : nxt;
      cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + TW'(1);
      pending_d = state_q != IDLE && (pending_q | sample_req);
      fwd_max = AIN1 > fwd_peak_q ? AIN1 : fwd_peak_q;
      rev_max = AIN2 > rev_peak_q ? AIN2 : rev_peak_q;
      fwd_power_d = capture ? AIN1 : fwd_power_q;
      rev_power_d = capture ? AIN2 : rev_power_q;
      fwd_peak_d = capture ? (peak_clear ? AIN1 : fwd_max) : (peak_clear ? '0 : fwd_peak_q);
      rev_peak_d = capture ? (peak_clear ? AIN2 : rev_max) : (peak_clear ? '0 : rev_peak_q);
      pwr_valid_d = capture;
      timeout_err_d = capture ? 1'b0 : (abort | timeout_err_q);
      pk_detect_reset_d = state_d == ARM;
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q           <= IDLE;
         cnt_q             <= '0;
         pending_q         <= 1'b0;
         pk_detect_reset_q <= 1'b0;
         busy_q            <= 1'b0;
         pwr_valid_q       <= 1'b0;
         timeout_err_q     <= 1'b0;
         fwd_power_q       <= '0;
         rev_power_q       <= '0;
         fwd_peak_q        <= '0;
         rev_peak_q        <= '0;
      end else begin
         state_q           <= state_d;
         cnt_q             <= cnt_d;
         pending_q         <= pending_d;
         pk_detect_reset_q <= pk_detect_reset_d;
         busy_q            <= busy_d;
         pwr_valid_q       <= pwr_valid_d;
         timeout_err_q     <= timeout_err_d;
         fwd_power_q       <= fwd_power_d;
         rev_power_q       <= rev_power_d;
         fwd_peak_q        <= fwd_peak_d;
         rev_peak_q        <= rev_peak_d;
      end
   end
   assign pk_detect_reset = pk_detect_reset_q;
   assign busy            = busy_q;
   assign pwr_valid       = pwr_valid_q;
   assign timeout_err     = timeout_err_q;
   assign fwd_power       = fwd_power_q;
   assign rev_power       = rev_power_q;
   assign fwd_peak        = fwd_peak_q;
   assign rev_peak        = rev_peak_q;
endmodule

// File: tb/tb_pk_detect_ctrl.sv
// tb_pk_detect_ctrl: directed, table-driven and randomized checks of pk_detect_ctrl
module tb_pk_detect_ctrl;
   localparam int TO = 16;
   logic clock = 1'b0, reset = 1'b1, sample_req = 1'b0, peak_clear = 1'b0, pk_detect_ack = 1'b0;
   logic [11:0] AIN1 = '0, AIN2 = '0;
   logic pk_detect_reset, pwr_valid, busy, timeout_err;
   logic [11:0] fwd_power, rev_power, fwd_peak, rev_peak;
   int tests = 0, fails = 0, pv_cnt = 0;
   typedef struct {
      logic clr;
      logic [11:0] a1, a2, e_fwd_pk, e_rev_pk;
   } vec_t;
   vec_t vt[5];
   pk_detect_ctrl #(.TIMEOUT_CYCLES(TO), .TW(5)) dut (
      .clock(clock), .reset(reset), .sample_req(sample_req), .peak_clear(peak_clear),
      .AIN1(AIN1), .AIN2(AIN2), .pk_detect_ack(pk_detect_ack), .pk_detect_reset(pk_detect_reset),
      .fwd_power(fwd_power), .rev_power(rev_power), .fwd_peak(fwd_peak), .rev_peak(rev_peak),
      .pwr_valid(pwr_valid), .busy(busy), .timeout_err(timeout_err)
   );
   always #5 clock = ~clock;
   always @(negedge clock) if (pwr_valid) pv_cnt++;
   task automatic tick;
      @(posedge clock);
      #1;
   endtask
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic wait_rst(input logic lvl, input string name);
      int n = 0;
      while (pk_detect_reset !== lvl && n < 50) begin
         tick;
         n++;
      end
      chk(name, 64'(pk_detect_reset), 64'(lvl));
   endtask
   task automatic wait_idle(input string name);
      int n = 0;
      while (busy !== 1'b0 && n < 50) begin
         tick;
         n++;
      end
      chk(name, 64'(busy), 64'd0);
   endtask
   task automatic pulse_req;
      sample_req = 1'b1;
      tick;
      sample_req = 1'b0;
   endtask
   task automatic serve(input logic [11:0] a1, input logic [11:0] a2, input int d_ack, input int d_rel);
      wait_rst(1'b1, "serve_rise");
      repeat (d_ack) tick;
      AIN1 = a1;
      AIN2 = a2;
      pk_detect_ack = 1'b1;
      tick;
      wait_rst(1'b0, "serve_fall");
      repeat (d_rel) tick;
      pk_detect_ack = 1'b0;
      tick;
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int p0, n;
      int ph, dly, run;
      bit silent, cap_next, clr_next;
      logic [11:0] m_fwd, m_rev, m_fpk, m_rpk, c1, c2;
      logic m_pv, m_terr;
      vt[0] = '{1'b1, 12'h100, 12'h00A, 12'h100, 12'h00A};
      vt[1] = '{1'b0, 12'h2FF, 12'h005, 12'h2FF, 12'h00A};
      vt[2] = '{1'b0, 12'h050, 12'h0F0, 12'h2FF, 12'h0F0};
      vt[3] = '{1'b1, 12'h010, 12'h001, 12'h010, 12'h001};
      vt[4] = '{1'b0, 12'h00F, 12'h002, 12'h010, 12'h002};
      repeat (3) tick;
      chk("reset_outputs", {fwd_power, rev_power, fwd_peak, rev_peak, pwr_valid, busy, timeout_err, pk_detect_reset}, 64'd0);
      reset = 1'b0;
      tick;
      p0 = pv_cnt;
      pulse_req;
      chk("t1_rst_hi", 64'(pk_detect_reset), 64'd1);
      chk("t1_busy", 64'(busy), 64'd1);
      repeat (5) tick;
      chk("t1_rst_hold", 64'(pk_detect_reset), 64'd1);
      AIN1 = 12'h3A5;
      AIN2 = 12'h012;
      pk_detect_ack = 1'b1;
      tick;
      chk("t1_rst_lo", 64'(pk_detect_reset), 64'd0);
      chk("t1_capture", {fwd_power, rev_power, pwr_valid}, {12'h3A5, 12'h012, 1'b1});
      tick;
      chk("t1_pv_pulse", 64'(pwr_valid), 64'd0);
      repeat (3) tick;
      pk_detect_ack = 1'b0;
      tick;
      chk("t1_idle", 64'(busy), 64'd0);
      chk("t1_pv_count", 64'(pv_cnt - p0), 64'd1);
      p0 = pv_cnt;
      pulse_req;
      n = 0;
      while (pk_detect_reset && n < 40) begin
         n++;
         tick;
      end
      chk("t2_hi_len", 64'(n), 64'(TO));
      chk("t2_timeout_err", 64'(timeout_err), 64'd1);
      chk("t2_idle", 64'(busy), 64'd0);
      chk("t2_no_pv", 64'(pv_cnt - p0), 64'd0);
      chk("t2_values_kept", {fwd_power, rev_power}, {12'h3A5, 12'h012});
      pulse_req;
      serve(12'h111, 12'h222, 2, 2);
      chk("t2_err_cleared", 64'(timeout_err), 64'd0);
      chk("t2_good_capture", {fwd_power, rev_power}, {12'h111, 12'h222});
      pk_detect_ack = 1'b1;
      pulse_req;
      chk("t3_drain_busy", 64'(busy), 64'd1);
      chk("t3_drain_rst", 64'(pk_detect_reset), 64'd0);
      repeat (3) tick;
      chk("t3_drain_hold", 64'(pk_detect_reset), 64'd0);
      pk_detect_ack = 1'b0;
      tick;
      chk("t3_arm", 64'(pk_detect_reset), 64'd1);
      AIN1 = 12'h0AB;
      AIN2 = 12'h0CD;
      pk_detect_ack = 1'b1;
      tick;
      chk("t3_capture", {fwd_power, rev_power, pwr_valid}, {12'h0AB, 12'h0CD, 1'b1});
      pk_detect_ack = 1'b0;
      tick;
      wait_idle("t3_idle");
      p0 = pv_cnt;
      pulse_req;
      tick;
      pulse_req;
      serve(12'h123, 12'h321, 1, 1);
      chk("t4_first", 64'(fwd_power), 64'h123);
      serve(12'h124, 12'h421, 1, 1);
      wait_idle("t4_idle");
      repeat (5) tick;
      chk("t4_pv_count", 64'(pv_cnt - p0), 64'd2);
      chk("t4_no_third", 64'(busy), 64'd0);
      for (int i = 0; i < 5; i++) begin
         if (vt[i].clr) begin
            peak_clear = 1'b1;
            tick;
            peak_clear = 1'b0;
            chk($sformatf("t5_clear_%0d", i), {fwd_peak, rev_peak}, 64'd0);
         end
         pulse_req;
         serve(vt[i].a1, vt[i].a2, 1, 0);
         chk($sformatf("t5_vec_%0d", i), {fwd_power, rev_power, fwd_peak, rev_peak},
             {vt[i].a1, vt[i].a2, vt[i].e_fwd_pk, vt[i].e_rev_pk});
      end
      pulse_req;
      AIN1 = 12'h001;
      AIN2 = 12'h002;
      pk_detect_ack = 1'b1;
      peak_clear = 1'b1;
      tick;
      peak_clear = 1'b0;
      chk("t5_clear_then_update", {fwd_peak, rev_peak}, {12'h001, 12'h002});
      pk_detect_ack = 1'b0;
      tick;
      wait_idle("t5_idle");
      pulse_req;
      chk("t6_arm", 64'(pk_detect_reset), 64'd1);
      reset = 1'b1;
      tick;
      chk("t6_all_zero", {fwd_power, rev_power, fwd_peak, rev_peak, pwr_valid, busy, timeout_err, pk_detect_reset}, 64'd0);
      reset = 1'b0;
      repeat (3) tick;
      chk("t6_pending_lost", {busy, pk_detect_reset}, 64'd0);
      ph = 0; dly = 0; run = 0; silent = 0; cap_next = 0; clr_next = 0;
      m_fwd = 0; m_rev = 0; m_fpk = 0; m_rpk = 0; m_pv = 0; m_terr = 0; c1 = 0; c2 = 0;
      for (int i = 0; i < 3000; i++) begin
         tick;
         if (cap_next) begin
            m_fwd = c1;
            m_rev = c2;
            m_terr = 1'b0;
            m_fpk = clr_next ? c1 : (c1 > m_fpk ? c1 : m_fpk);
            m_rpk = clr_next ? c2 : (c2 > m_rpk ? c2 : m_rpk);
         end else if (clr_next) begin
            m_fpk = 0;
            m_rpk = 0;
         end
         m_pv = cap_next;
         if (pk_detect_reset) begin
            run++;
            if (run > TO) chk("rnd_hi_len", 64'(run), 64'(TO));
         end else begin
            if (run > 0 && ph == 1 && silent) begin
               chk("rnd_timeout_len", 64'(run), 64'(TO));
               m_terr = 1'b1;
            end
            run = 0;
         end
         chk($sformatf("rnd_out_%0d", i), {fwd_power, rev_power, fwd_peak, rev_peak, pwr_valid, timeout_err},
             {m_fwd, m_rev, m_fpk, m_rpk, m_pv, m_terr});
         if (ph == 0 && pk_detect_reset) begin
            silent = $urandom_range(0, 7) == 0;
            dly = $urandom_range(0, 6);
            ph = 1;
         end
         if (ph == 1) begin
            if (!pk_detect_reset) ph = 0;
            else if (!silent) begin
               if (dly == 0) begin
                  c1 = 12'($urandom);
                  c2 = 12'($urandom);
                  AIN1 = c1;
                  AIN2 = c2;
                  pk_detect_ack = 1'b1;
                  ph = 2;
               end else dly--;
            end
         end
         if (ph == 2 && !pk_detect_reset) begin
            dly = $urandom_range(0, 6);
            ph = 3;
         end
         if (ph == 3) begin
            if (dly == 0) begin
               pk_detect_ack = 1'b0;
               ph = 0;
            end else dly--;
         end
         sample_req = $urandom_range(0, 5) == 0;
         peak_clear = $urandom_range(0, 11) == 0;
         clr_next = peak_clear;
         cap_next = pk_detect_reset && pk_detect_ack;
      end
      sample_req = 1'b0;
      peak_clear = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
